// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: compressor cell functions and width-derived sizes shared by approx_mult_pipe
package approx_mult_pkg;
  function automatic int nquad(input int w);
    return w / 4;
  endfunction
  function automatic int pw(input int w);
    return 2 * w;
  endfunction
  // Approximate 4:2 cell, returns {carry, sum}; column value is sum + 2*carry
  function automatic logic [1:0] approx_cell(input logic x1, input logic x2, input logic x3, input logic x4);
    logic p, q;
    p = x1 & x2;
    q = x3 & x4;
    return {p | q, (p & q) | (x1 ^ x2) | (x3 ^ x4)};
  endfunction
  function automatic logic [2:0] exact_count(input logic x1, input logic x2, input logic x3, input logic x4);
    return 3'(x1) + 3'(x2) + 3'(x3) + 3'(x4);
  endfunction
endpackage

// File: rtl/approx_quad_reduce.sv
// approx_quad_reduce: four partial-product rows to sum/carry vectors (value = sum + carry), per-column approx/exact
module approx_quad_reduce import approx_mult_pkg::*; #(
  parameter int PW = 16,
  parameter int APPROX_COLS = 8
) (
  input  logic [PW-1:0] r0,
  input  logic [PW-1:0] r1,
  input  logic [PW-1:0] r2,
  input  logic [PW-1:0] r3,
  input  logic          exact,
  output logic [PW-1:0] sum,
  output logic [PW-1:0] carry
);
  logic [PW:0] ci;
  logic [PW:0] cy;
  logic unused_msb;
  assign ci[0] = 1'b0;
  assign cy[0] = 1'b0;
  // Exact columns pass weight-2 pairs up a ripple chain so the remainder fits in one sum and one carry bit
  for (genvar c = 0; c < PW; c++) begin : g_col
    logic [1:0] ap;
    logic [2:0] cnt;
    logic       co;
    logic [1:0] t;
    logic       apx;
    assign ap = approx_cell(r0[c], r1[c], r2[c], r3[c]);
    assign cnt = exact_count(r0[c], r1[c], r2[c], r3[c]);
    assign co = cnt >= 3'd2;
    assign t = 2'(cnt - {1'b0, co, 1'b0}) + {1'b0, ci[c]};
    assign apx = (c < APPROX_COLS) && !exact;
    assign sum[c] = apx ? ap[0] : t[0];
    assign cy[c+1] = apx ? ap[1] : t[1];
    assign ci[c+1] = apx ? 1'b0 : co;
  end
  assign carry = cy[PW-1:0];
  assign unused_msb = ci[PW] ^ cy[PW];
endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage WIDTH x WIDTH multiplier on approximate 4:2 compressors with valid/ready.
// Define APPROX_ERR_MON_EN to add an exact-product error monitor (err_clr, err_count, err_max).
module approx_mult_pipe import approx_mult_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int APPROX_COLS = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_exact,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef APPROX_ERR_MON_EN
  input  logic                 err_clr,
  output logic [31:0]          err_count,
  output logic [2*WIDTH-1:0]   err_max,
`endif
  output logic [2*WIDTH-1:0]   out_p
);
  localparam int NQUAD = nquad(WIDTH);
  localparam int PW = pw(WIDTH);
  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  logic ex1;
  logic [PW-1:0] pp [WIDTH];
  logic [PW-1:0] rs [NQUAD];
  logic [PW-1:0] rc [NQUAD];
  logic [PW-1:0] s2s [NQUAD];
  logic [PW-1:0] s2c [NQUAD];
  logic [PW-1:0] total;
  assign ld3 = ~v3 | out_ready;
  assign ld2 = ~v2 | ld3;
  assign ld1 = ~v1 | ld2;
  assign in_ready = ld1;
  assign out_valid = v3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      for (int i = 0; i < WIDTH; i++) pp[i] <= PW'(in_a & {WIDTH{in_b[i]}}) << i;
      ex1 <= in_exact;
    end
    if (ld2 && v1) begin
      for (int k = 0; k < NQUAD; k++) begin
        s2s[k] <= rs[k];
        s2c[k] <= rc[k];
      end
    end
  end
  for (genvar k = 0; k < NQUAD; k++) begin : g_quad
    approx_quad_reduce #(.PW(PW), .APPROX_COLS(APPROX_COLS)) u_red (
      .r0(pp[4*k]),
      .r1(pp[4*k+1]),
      .r2(pp[4*k+2]),
      .r3(pp[4*k+3]),
      .exact(ex1),
      .sum(rs[k]),
      .carry(rc[k])
    );
  end
  always_comb begin
    total = '0;
    for (int k = 0; k < NQUAD; k++) total = total + s2s[k] + s2c[k];
  end
  // out_p only reloads with a real beat, so it holds its value while stalled or draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_p <= '0;
    else if (ld3 && v2) out_p <= total;
  end
`ifdef APPROX_ERR_MON_EN
  logic [WIDTH-1:0] a1, b1, a2, b2;
  logic [PW-1:0] ex3, diff;
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      a1 <= in_a;
      b1 <= in_b;
    end
    if (ld2 && v1) begin
      a2 <= a1;
      b2 <= b1;
    end
    if (ld3 && v2) ex3 <= PW'(a2) * PW'(b2);
  end
  assign diff = ex3 >= out_p ? ex3 - out_p : out_p - ex3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_max <= '0;
    end else if (err_clr) begin
      err_count <= '0;
      err_max <= '0;
    end else if (v3 && out_ready && diff != '0) begin
      err_count <= err_count + 32'(err_count != '1);
      if (diff > err_max) err_max <= diff;
    end
  end
`endif
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: directed and streamed checks of approx_mult_pipe (WIDTH=8) plus an APPROX_COLS=0 twin
module tb_approx_mult_pipe;
  localparam int W = 8;
  localparam int PW = 16;
  localparam int AC = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_exact = 1'b0;
  logic out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic in_ready, out_valid, in_ready0, out_valid0;
  logic [PW-1:0] out_p, out_p0;
`ifdef APPROX_ERR_MON_EN
  logic err_clr = 1'b0;
  logic [31:0] err_count, err_count0;
  logic [PW-1:0] err_max, err_max0;
`endif
  typedef struct packed {
    logic [PW-1:0] p;
    logic [PW-1:0] p0;
    int t;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int n_out = 0;
  logic [PW-1:0] nxt_exp, nxt_exp0, held_p;
  bit lat_chk = 0;
  bit held = 0;
  bit took = 0;
  bit rdy_s = 0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_exact(in_exact), .out_valid(out_valid), .out_ready(out_ready),
`ifdef APPROX_ERR_MON_EN
    .err_clr(err_clr), .err_count(err_count), .err_max(err_max),
`endif
    .out_p(out_p)
  );

  approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .in_exact(in_exact), .out_valid(out_valid0), .out_ready(out_ready),
`ifdef APPROX_ERR_MON_EN
    .err_clr(err_clr), .err_count(err_count0), .err_max(err_max0),
`endif
    .out_p(out_p0)
  );

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
    longint acc = 0;
    for (int k = 0; k < W / 4; k++) begin
      for (int c = 0; c < PW; c++) begin
        logic [3:0] x;
        logic [PW-1:0] row;
        int cc, ss;
        for (int j = 0; j < 4; j++) begin
          row = b[4*k+j] ? (PW'(a) << (4 * k + j)) : '0;
          x[j] = row[c];
        end
        cc = int'((x[0] & x[1]) | (x[2] & x[3]));
        ss = int'((x[0] & x[1] & x[2] & x[3]) | (x[0] ^ x[1]) | (x[2] ^ x[3]));
        if (c < AC && !e) acc += longint'(ss + 2 * cc) << c;
        else acc += longint'($countones(x)) << c;
      end
    end
    return PW'(acc);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc_n);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    rdy_s = in_ready;
    took = in_valid && in_ready;
    if (sb.size() == 0) check("idle_out_valid", 32'(out_valid), 0);
    if (out_valid && !out_ready) begin
      if (held) check("stall_hold", 32'(out_p), 32'(held_p));
      held = 1;
      held_p = out_p;
    end else held = 0;
    if (out_valid && out_ready && sb.size() != 0) begin
      exp_t e = sb.pop_front();
      check("out_p", 32'(out_p), 32'(e.p));
      check("out_p_exact_twin", 32'(out_p0), 32'(e.p0));
      if (lat_chk) check("latency", cyc_n - e.t, 3);
      n_out++;
    end
    if (took) sb.push_back('{nxt_exp, nxt_exp0, cyc_n});
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
    in_a = a;
    in_b = b;
    in_exact = e;
    nxt_exp = model(a, b, e);
    nxt_exp0 = PW'(a) * PW'(b);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic e, input logic [PW-1:0] want);
    load(a, b, e);
    nxt_exp = want;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) cyc();
    check("drain", sb.size(), 0);
  endtask

  task automatic stream(input int n, input bit rnd);
    logic [W-1:0] a = W'($urandom);
    logic [W-1:0] b = W'($urandom);
    logic e = 1'($urandom);
    int i = 0;
    n_out = 0;
    for (int t = 0; (i < n || sb.size() != 0) && t < 20 * n + 50; t++) begin
      out_ready = rnd ? ($urandom_range(0, 9) < 7) : !(t >= 5 && t < 10);
      in_valid = (i < n) && (rnd ? ($urandom_range(0, 9) < 7) : 1'b1);
      load(a, b, e);
      cyc();
      if (!rnd && t == 3) check("full_in_ready", 32'(rdy_s), 1);
      if (!rnd && t == 9) check("stall_in_ready", 32'(rdy_s), 0);
      if (took) begin
        i++;
        a = W'($urandom);
        b = W'($urandom);
        e = 1'($urandom);
      end
    end
    check("stream_count", n_out, n);
    out_ready = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_p", 32'(out_p), 0);
    rst = 1'b0;
    cyc();
    check("rst_in_ready", 32'(in_ready), 1);
    lat_chk = 1;
    send(8'h0F, 8'h0F, 1'b0, 16'h00D9);
    drain();
`ifdef APPROX_ERR_MON_EN
    check("err_count_first", err_count, 1);
    check("err_max_first", 32'(err_max), 8);
`endif
    send(8'h0F, 8'h0F, 1'b1, 16'h00E1);
    send(8'hFF, 8'hFF, 1'b1, 16'hFE01);
    send(8'h00, 8'hA5, 1'b0, 16'h0000);
    send(8'h00, 8'hA5, 1'b1, 16'h0000);
    send(8'h01, 8'h01, 1'b0, 16'h0001);
    send(8'hFF, 8'h01, 1'b0, 16'h00FF);
    send(8'h01, 8'hFF, 1'b0, 16'h00FF);
    drain();
`ifdef APPROX_ERR_MON_EN
    check("err_count_exact_beats", err_count, 1);
    check("err_max_exact_beats", 32'(err_max), 8);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("err_clr_count", err_count, 0);
    check("err_clr_max", 32'(err_max), 0);
`endif
    lat_chk = 0;
    stream(10, 1'b0);
    stream(400, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load(8'h33 + 8'(k), 8'h5A, 1'b0);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 0);
    sb.delete();
    held = 0;
`ifdef APPROX_ERR_MON_EN
    check("rst_err_count", err_count, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    lat_chk = 1;
    send(8'h0F, 8'h0F, 1'b0, 16'h00D9);
    drain();
`ifdef APPROX_ERR_MON_EN
    check("twin_err_count", err_count0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
